// File: rtl/vehicle_agent.sv
// Reactive vehicle/driver model for the far side of the parking-manager interface.
// Optional build macro VEHICLE_AGENT_TAILGATE_EN adds a tailgating second car during CROSS.
//
// state  | meaning
// IDLE   | no vehicle, waiting for start
// ARRIVE | sensorA up, vehicle pulling in
// PIN    | presenting a PIN attempt on pass
// WAIT   | attempt sent, waiting for the manager's verdict
// CROSS  | gate open, sensorB up while the car drives through
// EXIT   | both sensors clear for one cycle
// DONE   | one-cycle done pulse with result
module vehicle_agent #(
  parameter logic [7:0] PIN_GOOD     = 8'hA5,
  parameter int         PIN_HOLD     = 4,
  parameter int         GATE_TIMEOUT = 64,
  parameter int         CROSS_CYC    = 8,
  parameter int         MAX_TRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] bad_tries,
  input  logic       gateState,
  input  logic       wrongPinAlarm,
  input  logic       blockAlarm,
  output logic       sensorA,
  output logic       sensorB,
  output logic [7:0] pass,
  output logic       done,
  output logic [1:0] result
);
  localparam int CW = 16;
  localparam logic [CW-1:0] ARRIVE_LAST = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(PIN_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(GATE_TIMEOUT - 1);
  localparam logic [CW-1:0] CROSS_LAST  = CW'(CROSS_CYC - 1);
  localparam logic [2:0]    MAX_T       = 3'(MAX_TRIES);
`ifdef VEHICLE_AGENT_TAILGATE_EN
  localparam logic [CW-1:0] CROSS_HALF  = CW'(CROSS_CYC / 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ARRIVE, S_PIN, S_WAIT, S_CROSS, S_EXIT, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      tries, tries_d, bad_q, bad_d;
  logic [1:0]      result_d;
  logic            sensor_a_d, sensor_b_d, done_d;
  logic [7:0]      pass_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tries   <= '0;
      bad_q   <= '0;
      result  <= 2'b00;
      sensorA <= 1'b0;
      sensorB <= 1'b0;
      pass    <= 8'h00;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      tries   <= tries_d;
      bad_q   <= bad_d;
      result  <= result_d;
      sensorA <= sensor_a_d;
      sensorB <= sensor_b_d;
      pass    <= pass_d;
      done    <= done_d;
    end
  end

  always_comb begin
    nxt      = state;
    cnt_d    = cnt + 1'b1;
    tries_d  = tries;
    bad_d    = bad_q;
    result_d = result;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nxt      = S_ARRIVE;
          bad_d    = bad_tries;
          tries_d  = '0;
          result_d = 2'b00;
        end
      end
      S_ARRIVE: begin
        if (blockAlarm) begin
          nxt      = S_DONE;
          result_d = 2'b11;
        end else if (cnt == ARRIVE_LAST) nxt = S_PIN;
      end
      S_PIN: begin
        if (blockAlarm) begin
          nxt      = S_DONE;
          result_d = 2'b11;
        end else if (cnt == HOLD_LAST) begin
          nxt     = S_WAIT;
          tries_d = tries + 3'd1;
        end
      end
      S_WAIT: begin
        if (blockAlarm) begin
          nxt      = S_DONE;
          result_d = 2'b11;
        end else if (gateState) nxt = S_CROSS;
        else if (wrongPinAlarm && (tries < MAX_T)) nxt = S_PIN;
        else if (wrongPinAlarm || (cnt == WAIT_LAST)) begin
          nxt      = S_DONE;
          result_d = 2'b10;
        end
      end
      S_CROSS: begin
`ifdef VEHICLE_AGENT_TAILGATE_EN
        if (blockAlarm) begin
          nxt      = S_DONE;
          result_d = 2'b11;
        end else
`endif
        if (cnt == CROSS_LAST) nxt = S_EXIT;
      end
      S_EXIT: begin
        nxt      = S_DONE;
        result_d = 2'b01;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // Every state's timer starts at zero on entry.
    if ((nxt != state) || (state == S_IDLE)) cnt_d = '0;

    sensor_a_d = (nxt == S_ARRIVE) || (nxt == S_PIN) || (nxt == S_WAIT);
    sensor_b_d = (nxt == S_CROSS);
`ifdef VEHICLE_AGENT_TAILGATE_EN
    if ((nxt == S_CROSS) && (cnt_d >= CROSS_HALF)) sensor_a_d = 1'b1;
`endif
    pass_d = 8'h00;
    if (nxt == S_PIN) pass_d = (tries < bad_q) ? ~PIN_GOOD : PIN_GOOD;
    done_d = (nxt == S_DONE);
  end
endmodule

// File: tb/tb_vehicle_agent.sv
// Directed closed-loop bench for vehicle_agent; the initial block plays the parking manager.
// Honours VEHICLE_AGENT_TAILGATE_EN for the sensor-overlap expectations.
module tb_vehicle_agent;
  logic       clk = 1'b0;
  logic       reset, start, gateState, wrongPinAlarm, blockAlarm;
  logic [2:0] bad_tries;
  logic       sensorA, sensorB, done;
  logic [7:0] pass;
  logic [1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pin_q[$];
  logic [1:0] res_q[$];
  int         bcnt_q[$];

  logic [7:0] prev_pass = 8'h00;
  int         hold_cnt  = 0;
  int         b_cnt     = 0;
  bit         overlap   = 1'b0;

  vehicle_agent dut (
    .clk(clk), .reset(reset), .start(start), .bad_tries(bad_tries),
    .gateState(gateState), .wrongPinAlarm(wrongPinAlarm), .blockAlarm(blockAlarm),
    .sensorA(sensorA), .sensorB(sensorB), .pass(pass), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Scoreboard side: PIN attempts, hold length, crossing length and result per vehicle.
  always @(negedge clk) begin
    if (reset) begin
      prev_pass = 8'h00;
      hold_cnt  = 0;
      b_cnt     = 0;
    end else begin
      if (pass != 8'h00 && prev_pass == 8'h00) begin
        hold_cnt = 1;
        if (pin_q.size() == 0) bound_fail("unexpected_pin");
        else check("pin_value", pass, pin_q.pop_front());
      end else if (pass != 8'h00) begin
        hold_cnt++;
      end else if (prev_pass != 8'h00) begin
        check("pin_hold", hold_cnt, 4);
      end
      prev_pass = pass;
      if (sensorB) b_cnt++;
`ifndef VEHICLE_AGENT_TAILGATE_EN
      if (sensorA && sensorB) overlap = 1'b1;
`endif
      if (done) begin
        if (res_q.size() == 0) bound_fail("unexpected_done");
        else begin
          check("result", result, res_q.pop_front());
          check("cross_cycles", b_cnt, bcnt_q.pop_front());
          check("done_sensors", {sensorA, sensorB, pass}, 10'h000);
        end
        b_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] bad, input int n_bad, input int n_good,
                        input logic [1:0] res, input int bcyc);
    for (int i = 0; i < n_bad; i++) pin_q.push_back(8'h5A);
    for (int i = 0; i < n_good; i++) pin_q.push_back(8'hA5);
    res_q.push_back(res);
    bcnt_q.push_back(bcyc);
    tick(1);
    bad_tries = bad;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_pin_end();
    bit seen, ok;
    seen = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (pass != 8'h00) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("pin_end_wait");
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("done_wait");
  endtask

  // which: 0 gate, 1 wrong PIN, 2 block together with gate
  task automatic respond(input int which, input int dly);
    tick(dly);
    case (which)
      0: gateState = 1'b1;
      1: wrongPinAlarm = 1'b1;
      default: begin
        blockAlarm = 1'b1;
        gateState  = 1'b1;
      end
    endcase
    tick(1);
    gateState = 1'b0;
    wrongPinAlarm = 1'b0;
    blockAlarm = 1'b0;
  endtask

  initial begin
    int k;
    bit ok;
    reset = 1'b1;
    start = 1'b0;
    bad_tries = 3'd0;
    gateState = 1'b0;
    wrongPinAlarm = 1'b0;
    blockAlarm = 1'b0;
    tick(2);
    check("rst_sensors", {sensorA, sensorB}, 2'b00);
    check("rst_pass", pass, 8'h00);
    check("rst_done_result", {done, result}, 3'b000);
    reset = 1'b0;
    tick(2);

    // 1: good PIN first time, gate opens; start during DONE is ignored
    launch(3'd0, 0, 1, 2'b01, 8);
    wait_pin_end();
    respond(0, 3);
    wait_done();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("start_in_done_ignored", sensorA, 1'b0);
    check("result_held", {done, result}, 3'b001);

    // 2: two bad PINs rejected, good one accepted
    launch(3'd2, 2, 1, 2'b01, 8);
    check("result_cleared", result, 2'b00);
    wait_pin_end();
    respond(1, 2);
    wait_pin_end();
    respond(1, 2);
    wait_pin_end();
    respond(0, 1);
    wait_done();
    tick(2);

    // 3: all three attempts wrong
    launch(3'd3, 3, 0, 2'b10, 0);
    for (int i = 0; i < 3; i++) begin
      wait_pin_end();
      respond(1, 1);
    end
    wait_done();
    tick(2);

    // 4: silent manager, timeout 64 cycles after WAIT entry
    launch(3'd0, 0, 1, 2'b10, 0);
    wait_pin_end();
    ok = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("timeout_wait");
    else check("timeout_latency", k, 64);
    tick(2);

    // 5: block wins over gate
    launch(3'd0, 0, 1, 2'b11, 0);
    wait_pin_end();
    respond(2, 1);
    wait_done();
    tick(2);

    // 6: reset mid-CROSS, then a normal vehicle
    launch(3'd0, 0, 1, 2'b01, 8);
    wait_pin_end();
    respond(0, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sensorB) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("cross_wait");
    repeat (4) @(negedge clk);
`ifdef VEHICLE_AGENT_TAILGATE_EN
    check("cross4_sensors", {sensorA, sensorB}, 2'b11);
`else
    check("cross4_sensors", {sensorA, sensorB}, 2'b01);
`endif
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_outputs", {sensorA, sensorB, pass, done, result}, 13'h0000);
    pin_q.delete();
    res_q.delete();
    bcnt_q.delete();
    @(negedge clk);
    tick(1);
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ok = 1'b0;
    end
    check("no_done_after_reset", ok, 1'b1);
    launch(3'd0, 0, 1, 2'b01, 8);
    wait_pin_end();
    respond(0, 2);
    wait_done();
    tick(2);

    check("queues_drained", res_q.size() + pin_q.size(), 0);
`ifndef VEHICLE_AGENT_TAILGATE_EN
    check("no_sensor_overlap", overlap, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
